// File: rtl/instr_fetch.sv
// instr_fetch: walks a PC through synchronous instruction memory into a 2-entry valid/ready buffer with redirect flush.
// Optional single-step credit mode is enabled by defining INSTR_FETCH_STEP_EN.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  output logic [ADDR_W-1:0] o_MemAddr,
  output logic              o_MemRd,
  input  logic [15:0]       i_MemData,
  output logic [15:0]       o_Instr,
  output logic              o_InstrValid,
  input  logic              i_DecReady,
  output logic [ADDR_W-1:0] o_PC,
  input  logic              i_Redirect,
  input  logic [ADDR_W-1:0] i_RedirectPC,
  input  logic              i_Step
);
  logic [ADDR_W-1:0] fpc, inf_addr;
  logic [15:0] q_instr [2];
  logic [ADDR_W-1:0] q_pc [2];
  logic [1:0] occ, rem;
  logic [2:0] load;
  logic inf, pop, head_ok;
`ifdef INSTR_FETCH_STEP_EN
  logic step_q, credit;
  assign head_ok = credit;
  always_ff @(posedge i_CLK or posedge i_RST)
    if (i_RST) begin
      step_q <= 1'b0;
      credit <= 1'b0;
    end else begin
      step_q <= i_Step;
      credit <= (pop && !i_Redirect) ? 1'b0 : credit | (i_Step & ~step_q);
    end
`else
  logic unused_step;
  assign unused_step = i_Step;
  assign head_ok = 1'b1;
`endif
  assign o_InstrValid = (occ != 2'd0) && head_ok;
  assign pop = o_InstrValid && i_DecReady;
  assign load = {1'b0, occ} + {2'b0, inf} - {2'b0, pop};
  assign rem = occ - {1'b0, pop};
  assign o_MemRd = !i_RST && !i_Redirect && (load < 3'd2);
  assign o_MemAddr = fpc;
  assign o_Instr = (occ != 2'd0) ? q_instr[0] : 16'h0000;
  assign o_PC = (occ != 2'd0) ? q_pc[0] : '0;
  // rem is the occupancy after the pop, so the captured word lands right behind the surviving head
  always_ff @(posedge i_CLK or posedge i_RST)
    if (i_RST) begin
      fpc <= RESET_PC;
      occ <= 2'd0;
      inf <= 1'b0;
      inf_addr <= '0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
      q_pc[0] <= '0;
      q_pc[1] <= '0;
    end else if (i_Redirect) begin
      fpc <= i_RedirectPC;
      occ <= 2'd0;
      inf <= 1'b0;
    end else begin
      inf <= o_MemRd;
      inf_addr <= fpc;
      if (o_MemRd) fpc <= fpc + 1'b1;
      if (pop) begin
        q_instr[0] <= q_instr[1];
        q_pc[0] <= q_pc[1];
      end
      if (inf) begin
        q_instr[rem[0]] <= i_MemData;
        q_pc[rem[0]] <= inf_addr;
      end
      occ <= rem + {1'b0, inf};
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed checks of instr_fetch against an in-order fetch-stream model.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] mem_addr, pc, redirect_pc;
  logic mem_rd, valid, ready, redirect, step;
  logic [15:0] mem_data, instr;
  logic [15:0] mem [256];
  logic [7:0] exp_pc;
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .i_CLK(clk), .i_RST(rst), .o_MemAddr(mem_addr), .o_MemRd(mem_rd),
    .i_MemData(mem_data), .o_Instr(instr), .o_InstrValid(valid),
    .i_DecReady(ready), .o_PC(pc), .i_Redirect(redirect),
    .i_RedirectPC(redirect_pc), .i_Step(step)
  );

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pattern();
    for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0; step = 1'b0;
    fill_pattern();
    tick(); tick();
    vectors++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", mem_addr); end
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", mem_rd); end
    vectors++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", instr); end
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    vectors++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", pc); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    rst = 1'b0; ready = 1'b1;
    #1;
    vectors++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("FAIL first_read got rd=%b addr=%h want rd=1 addr=00", mem_rd, mem_addr); end
    tick();
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_e0 valid got %b want 0", valid); end
    tick();
    exp_pc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (valid !== 1'b1 || pc !== exp_pc || instr !== mem[exp_pc]) begin
        errors++; $display("FAIL stream got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", valid, pc, instr, exp_pc, mem[exp_pc]);
      end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    logic [7:0] held_pc;
    held = instr; held_pc = pc;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (instr !== held || pc !== held_pc || valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", valid, pc, instr, held_pc, held);
      end
      vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL bp_rd cycle %0d got %b want 0", i, mem_rd); end
    end
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (valid !== 1'b1 || pc !== exp_pc || instr !== mem[exp_pc]) begin
        errors++; $display("FAIL bp_resume got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", valid, pc, instr, exp_pc, mem[exp_pc]);
      end
      exp_pc++;
      tick();
    end
  endtask

  task automatic redirect_to(input logic [7:0] target, input int pops);
    redirect = 1'b1; redirect_pc = target;
    #1;
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL redir_rd got %b want 0", mem_rd); end
    tick();
    redirect = 1'b0; redirect_pc = $urandom;
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL redir_r0 valid got %b want 0", valid); end
    tick();
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL redir_r1 valid got %b want 0", valid); end
    tick();
    exp_pc = target;
    for (int i = 0; i < pops; i++) begin
      vectors++;
      if (valid !== 1'b1 || pc !== exp_pc || instr !== mem[exp_pc]) begin
        errors++; $display("FAIL redir_seq got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", valid, pc, instr, exp_pc, mem[exp_pc]);
      end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_redirect();
    redirect_to(8'h40, 3);
  endtask

  task automatic test_wrap();
    redirect_to(8'hFE, 4);
  endtask

  task automatic test_random();
    logic hold, r_redir, r_ready;
    logic [15:0] held;
    logic [7:0] held_pc, r_pc;
    int since;
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    redirect_to(8'($urandom), 2);
    hold = 1'b0; since = 3;
    for (int c = 0; c < 400; c++) begin
      r_ready = 1'($urandom);
      r_redir = ($urandom_range(0, 15) == 0);
      r_pc = 8'($urandom);
      ready = r_ready; redirect = r_redir; redirect_pc = r_pc; step = 1'($urandom);
      #1;
      if (since >= 2) begin
        vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL rnd_live cycle %0d got %b want 1", c, valid); end
      end else begin
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL rnd_gap cycle %0d got %b want 0", c, valid); end
      end
      if (hold) begin
        vectors++; if (instr !== held || pc !== held_pc) begin errors++; $display("FAIL rnd_hold got pc=%h ins=%h want pc=%h ins=%h", pc, instr, held_pc, held); end
      end
      if (r_redir) begin
        vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rnd_redir_rd got %b want 0", mem_rd); end
        exp_pc = r_pc; since = 0;
      end else begin
        if (valid && r_ready) begin
          vectors++;
          if (pc !== exp_pc || instr !== mem[exp_pc]) begin
            errors++; $display("FAIL rnd_pop got pc=%h ins=%h want pc=%h ins=%h", pc, instr, exp_pc, mem[exp_pc]);
          end
          exp_pc++;
        end
        since++;
      end
      hold = valid && !r_ready && !r_redir;
      held = instr; held_pc = pc;
      tick();
    end
    redirect = 1'b0; ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    vectors++; if (valid !== 1'b0 || instr !== 16'h0000 || pc !== 8'h00) begin errors++; $display("FAIL midrst_out got v=%b ins=%h pc=%h want 0 0000 00", valid, instr, pc); end
    vectors++; if (mem_rd !== 1'b0 || mem_addr !== 8'h00) begin errors++; $display("FAIL midrst_mem got rd=%b addr=%h want 0 00", mem_rd, mem_addr); end
    tick(); tick();
    @(negedge clk);
    rst = 1'b0; ready = 1'b1;
    #1;
    vectors++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("FAIL midrst_first got rd=%b addr=%h want 1 00", mem_rd, mem_addr); end
    tick(); tick();
    exp_pc = 8'h00;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (valid !== 1'b1 || pc !== exp_pc || instr !== mem[exp_pc]) begin
        errors++; $display("FAIL midrst_seq got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", valid, pc, instr, exp_pc, mem[exp_pc]);
      end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_step();
    @(negedge clk);
    rst = 1'b0; ready = 1'b1; step = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL step_idle got %b want 0", valid); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      vectors++;
      if (valid !== 1'b1 || pc !== 8'(k) || instr !== 16'h1000 + 16'(k)) begin
        errors++; $display("FAIL step_pop got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", valid, pc, instr, 8'(k), 16'h1000 + 16'(k));
      end
      for (int w = 0; w < 3; w++) begin
        tick();
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL step_after got %b want 0", valid); end
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef INSTR_FETCH_STEP_EN
    test_step();
`else
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_random();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
